// File: rtl/l2_bus_arbiter.sv
// Round-robin arbiter sharing one L2 slave port among NUM_MASTERS L1 miss ports; one transaction in flight.
// Latency: request in IDLE -> s_en next cycle; s_en held from a latched buffer until s_ready, then one IDLE cycle.
module l2_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_BITS     = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [32*NUM_MASTERS-1:0] m_addr,
    input  logic [32*NUM_MASTERS-1:0] m_wdata,
    input  logic [4*NUM_MASTERS-1:0]  m_be,
    input  logic [NUM_MASTERS-1:0]    m_we,
    input  logic [NUM_MASTERS-1:0]    m_en,
    output logic [32*NUM_MASTERS-1:0] m_rdata,
    output logic [NUM_MASTERS-1:0]    m_ready,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    output logic [3:0]                s_be,
    output logic                      s_we,
    output logic                      s_en,
    input  logic [31:0]               s_rdata,
    input  logic                      s_ready,
    output logic                      busy,
    output logic [ID_BITS-1:0]        grant_id
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic               we_q, we_d;
    logic [ID_BITS-1:0] cur_grant_q, cur_grant_d;
    logic [ID_BITS-1:0] last_grant_q, last_grant_d;

    logic [31:0]        addr_arr  [NUM_MASTERS];
    logic [31:0]        wdata_arr [NUM_MASTERS];
    logic [3:0]         be_arr    [NUM_MASTERS];
    logic [ID_BITS-1:0] sel;
    logic [ID_BITS-1:0] idx;
    logic               sel_vld;

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign addr_arr[g]  = m_addr[32*g +: 32];
        assign wdata_arr[g] = m_wdata[32*g +: 32];
        assign be_arr[g]    = m_be[4*g +: 4];
    end

    // Search starts just past the last winner, so the previous owner ends up lowest priority.
    always_comb begin
        sel     = last_grant_q;
        idx     = last_grant_q;
        sel_vld = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = ID_BITS'((int'(last_grant_q) + i) % NUM_MASTERS);
            if (!sel_vld && m_en[idx]) begin
                sel_vld = 1'b1;
                sel     = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        we_d         = we_q;
        cur_grant_d  = cur_grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    addr_d      = addr_arr[sel];
                    wdata_d     = wdata_arr[sel];
                    be_d        = be_arr[sel];
                    we_d        = m_we[sel];
                    cur_grant_d = sel;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (s_ready) begin
                    last_grant_d = cur_grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            we_q         <= 1'b0;
            cur_grant_q  <= '0;
            last_grant_q <= ID_BITS'(NUM_MASTERS - 1);
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            we_q         <= we_d;
            cur_grant_q  <= cur_grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Slave-side fields are zeroed outside a transaction so the L2 never sees stale data with s_en low.
    always_comb begin
        busy     = (state_q == BUSY);
        s_en     = busy;
        s_addr   = busy ? addr_q  : '0;
        s_wdata  = busy ? wdata_q : '0;
        s_be     = busy ? be_q    : '0;
        s_we     = busy & we_q;
        grant_id = cur_grant_q;
    end

    always_comb begin
        m_ready = '0;
        m_rdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (busy && s_ready && cur_grant_q == ID_BITS'(i)) begin
                m_ready[i]          = 1'b1;
                m_rdata[32*i +: 32] = s_rdata;
            end
        end
    end

endmodule

// File: doc/l2_bus_arbiter.md
Name: l2_bus_arbiter

Overview:
- Shares the single L2 cache slave port between NUM_MASTERS requesters (per-core L1 I-cache and D-cache miss ports).
- Arbitration is round-robin with a transaction lock. The winning request is latched into a request buffer, and the L2 port is driven from that buffer until the L2 returns s_ready.
- Sits between the L1 caches and the L2 cache. Exactly one L2 transaction is outstanding at any time.

Parameters:
- NUM_MASTERS, 4, number of requesting ports (2..8).
- ID_BITS, 2, width of the grant index; must equal clog2(NUM_MASTERS).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- m_addr  input  32*NUM_MASTERS  per-master byte address; master i uses bits [32i+31:32i]
- m_wdata  input  32*NUM_MASTERS  per-master write data
- m_be  input  4*NUM_MASTERS  per-master byte enables
- m_we  input  NUM_MASTERS  per-master write flag
- m_en  input  NUM_MASTERS  per-master request valid
- m_rdata  output  32*NUM_MASTERS  per-master read data
- m_ready  output  NUM_MASTERS  per-master completion pulse
- s_addr  output  32  to L2 slave address
- s_wdata  output  32  to L2 write data
- s_be  output  4  to L2 byte enables
- s_we  output  1  to L2 write flag
- s_en  output  1  to L2 request
- s_rdata  input  32  from L2 read data
- s_ready  input  1  from L2 completion
- busy  output  1  high while a transaction is in flight
- grant_id  output  ID_BITS  index of the current or last granted master

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; request buffer (addr, wdata, be, we) cleared.
  - last_grant = NUM_MASTERS-1, so master 0 has first priority.
  - All outputs are 0.
- FSM states: IDLE, BUSY.
- IDLE:
  - s_en=0.
  - If any m_en is high, select the first requester at or after (last_grant+1), wrapping modulo NUM_MASTERS.
  - On the next clk edge: latch that master's addr, wdata, be and we into the buffer; cur_grant <= selection; go to BUSY.
  - If no m_en is high, stay in IDLE.
- BUSY:
  - s_en=1; s_addr, s_wdata, s_be and s_we come from the buffer and are stable for the whole transaction.
  - busy=1; grant_id=cur_grant.
  - When s_ready=1 in a cycle, in that same cycle (combinational): m_ready[cur_grant]=1 and m_rdata[cur_grant]=s_rdata. For writes, m_rdata is passed through and is don't-care.
  - On that clk edge: last_grant <= cur_grant; go to IDLE.
- m_rdata lanes other than the granted one are 0; m_ready is one-hot or zero.
- Latency:
  - Arbitration adds one cycle: a request seen in IDLE produces s_en on the next cycle.
  - One mandatory IDLE cycle separates back-to-back transactions, so the L2 FSM always returns to its idle state before a new s_en.
- Minimum request-to-m_ready time is 2 cycles (L2 read hit).
- Masters hold m_en and their fields until m_ready.
  - If a granted master drops m_en while BUSY, the buffered transaction still completes and m_ready still pulses.
  - The master ignores that pulse. No abort path exists.
- A master that keeps m_en high after its m_ready re-enters arbitration with lowest priority. No master waits more than NUM_MASTERS-1 transactions.
- Simultaneous events:
  - New requests arriving while BUSY are not sampled until IDLE.
  - m_en from the just-finished master in the s_ready cycle is not considered, since arbitration only happens in IDLE.
- s_ready while in IDLE is ignored.
- grant_id holds its value in IDLE. busy=0 in IDLE.
- Reset mid-transaction: the FSM returns to IDLE immediately and no m_ready is produced. The L2 is reset by the same rst_n.

Test Plan:
- Single read: m_en[2]=1, m_addr[2]=0x0000_1004, L2 returns s_rdata=0xDEADBEEF with s_ready 1 cycle after s_en.
  -> s_addr=0x0000_1004 with s_we=0; m_ready[2] pulses one cycle with m_rdata[2]=0xDEADBEEF; grant_id=2.
- Round-robin fairness: all 4 m_en held high, each L2 access takes 3 cycles.
  -> grant order 0,1,2,3,0; each m_ready is a single pulse; one IDLE cycle between transactions.
- Write passthrough: m_en[1]=1, m_we[1]=1, m_addr=0x2000, m_wdata=0x12345678, m_be=4'b0011.
  -> s_we=1, s_be=0011, s_wdata=0x12345678 stable until s_ready; m_ready[1] pulses.
- Buffer hold: master 3 granted, then changes m_addr to 0xFFFF_0000 and drops m_en before s_ready.
  -> s_addr keeps the latched value; m_ready[3] still pulses; next grant goes to the next requester.
- Priority rotation: master 1 finishes while masters 0 and 1 both keep m_en high.
  -> next grant=0, then 1.
- Reset mid-op: assert rst_n=0 while BUSY.
  -> s_en=0, busy=0, m_ready=0 immediately; after release, first grant goes to the lowest-index requester.
